// File: rtl/alu_arbiter_if.sv
// Request/response bundle between the two ALU requesters and alu_arbiter.
// The master modport is the requester side and the slave modport is the arbiter side.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_OPCODE
`define W_OPCODE 6
`endif

interface alu_arbiter_if #(
  parameter int W_DATA = `W_CPU,
  parameter int W_OP   = `W_OPCODE
) ();
  logic              req0_valid;
  logic              req0_ready;
  logic [W_OP-1:0]   req0_op;
  logic [W_DATA-1:0] req0_a;
  logic [W_DATA-1:0] req0_b;

  logic              req1_valid;
  logic              req1_ready;
  logic [W_OP-1:0]   req1_op;
  logic [W_DATA-1:0] req1_a;
  logic [W_DATA-1:0] req1_b;

  logic              rsp0_valid;
  logic              rsp0_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [W_DATA-1:0] rsp_r;
  logic              rsp_overflow;
  logic              rsp_zero;

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp0_ready, rsp1_ready,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp1_valid, rsp_r, rsp_overflow, rsp_zero
  );

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp1_valid, rsp_r, rsp_overflow, rsp_zero
  );
endinterface

// File: rtl/alu_arbiter.sv
// Two-port arbiter sharing one ALU: accept -> EXEC -> RESP, response valid two cycles after accept.
// Round-robin on ties; define ALU_ARB_FIXED_PRIO_EN to give port 0 strict priority.
`ifndef W_CPU
`define W_CPU 32
`endif
`ifndef W_OPCODE
`define W_OPCODE 6
`endif

module alu_arbiter #(
  parameter int W_DATA = `W_CPU,
  parameter int W_OP   = `W_OPCODE
) (
  input  logic              clk,
  input  logic              rst,
  alu_arbiter_if.slave      bus,
  output logic [W_OP-1:0]   alu_op,
  output logic [W_DATA-1:0] alu_a,
  output logic [W_DATA-1:0] alu_b,
  input  logic [W_DATA-1:0] alu_r,
  input  logic              alu_overflow,
  input  logic              alu_zero
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;

  logic              owner;
  logic              rr_pri;
  logic              winner;
  logic              any_vld;
  logic              both_vld;
  logic              accept;
  logic              capture;
  logic              rdy0;
  logic              rdy1;
  logic              vld0;
  logic              vld1;

  logic [W_DATA-1:0] r_q;
  logic              ovf_q;
  logic              zero_q;

  assign any_vld  = bus.req0_valid | bus.req1_valid;
  assign both_vld = bus.req0_valid & bus.req1_valid;
  // rr_pri never leaves 0 in the fixed-priority build, so ties always go to port 0 there.
  assign winner   = both_vld ? rr_pri : ~bus.req0_valid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    capture   = 1'b0;
    rdy0      = 1'b0;
    rdy1      = 1'b0;
    vld0      = 1'b0;
    vld1      = 1'b0;
    case (state)
      IDLE: begin
        if (any_vld) begin
          accept    = 1'b1;
          rdy0      = ~winner;
          rdy1      = winner;
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        capture   = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        vld0 = ~owner;
        vld1 = owner;
        // Only the owning port's ready retires the response.
        if (owner ? bus.rsp1_ready : bus.rsp0_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      owner  <= 1'b0;
      rr_pri <= 1'b0;
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
      r_q    <= '0;
      ovf_q  <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      if (accept) begin
        owner  <= winner;
        alu_op <= winner ? bus.req1_op : bus.req0_op;
        alu_a  <= winner ? bus.req1_a  : bus.req0_a;
        alu_b  <= winner ? bus.req1_b  : bus.req0_b;
`ifndef ALU_ARB_FIXED_PRIO_EN
        if (both_vld) begin
          rr_pri <= ~winner;
        end
`endif
      end
      if (capture) begin
        r_q    <= alu_r;
        ovf_q  <= alu_overflow;
        zero_q <= alu_zero;
      end
    end
  end

  assign bus.req0_ready   = rdy0;
  assign bus.req1_ready   = rdy1;
  assign bus.rsp0_valid   = vld0;
  assign bus.rsp1_valid   = vld1;
  assign bus.rsp_r        = r_q;
  assign bus.rsp_overflow = ovf_q;
  assign bus.rsp_zero     = zero_q;

endmodule
